// File: rtl/edge_pkg.sv
// Shared definitions for the edge event arbiter: channel mode encodings and the
// event payload carried towards the downstream consumer.
package edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Channel field sized for the largest supported configuration (32 channels).
  localparam int unsigned EVT_CH_W = 5;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                rising;
  } edge_evt_t;

  function automatic logic mode_has_rise(input logic [1:0] mode);
    return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
  endfunction

  function automatic logic mode_has_fall(input logic [1:0] mode);
    return (mode != EDGE_OFF) && (mode != EDGE_RISE);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning last+1, last+2, ...
// modulo N_CH. The rotation pointer itself lives in the parent.
module rr_arbiter #(
  parameter  int unsigned N_CH  = 8,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan farthest-first so the nearest candidate after 'last' overwrites the rest.
  always_comb begin
    int unsigned pos;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    for (int unsigned k = N_CH; k >= 1; k--) begin
      pos = 32'(last) + k;
      if (pos >= N_CH) begin
        pos = pos - N_CH;
      end
      if (req[pos]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection with one pending event per channel, serialised onto
// a single valid/ready stream by a round-robin scheduler.
module edge_event_arbiter
  import edge_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     in,
  input  logic [2*N_CH-1:0]   cfg_mode,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_ch,
  output logic                evt_edge,
  output logic [N_CH-1:0]     overflow,
  input  logic [N_CH-1:0]     ovf_clr
);

  logic [N_CH-1:0]  in_d;
  logic             primed;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  pend_edge;
  logic [IDX_W-1:0] rr_last;

  logic [N_CH-1:0]  rise_en;
  logic [N_CH-1:0]  fall_en;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  det;
  logic [N_CH-1:0]  gnt_mask;
  logic [N_CH-1:0]  pend_kept;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  ovf_set;
  logic [N_CH-1:0]  pend_nxt;
  logic [N_CH-1:0]  pend_edge_nxt;
  logic [N_CH-1:0]  overflow_nxt;
  logic             load;
  logic             take;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  // Per-channel mode decode.
  always_comb begin
    rise_en = '0;
    fall_en = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rise_en[i] = mode_has_rise(cfg_mode[2*i +: 2]);
      fall_en[i] = mode_has_fall(cfg_mode[2*i +: 2]);
    end
  end

  // Detection is held off until in_d holds a real sample (priming cycle).
  assign rise = in & ~in_d & rise_en & {N_CH{primed}};
  assign fall = ~in & in_d & fall_en & {N_CH{primed}};
  assign det  = rise | fall;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .req       (pend),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load = ~evt_valid | evt_ready;
  assign take = load & gnt_valid;

  // Pending/overflow update; a grant this cycle frees the slot for a new detection.
  always_comb begin
    gnt_mask      = take ? (N_CH'(1) << gnt_idx) : '0;
    pend_kept     = pend & ~gnt_mask;
    accept        = det & ~pend_kept;
    ovf_set       = det & pend_kept;
    pend_nxt      = pend_kept | det;
    pend_edge_nxt = (pend_edge & ~accept) | (rise & accept);
    overflow_nxt  = (overflow & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d      <= '0;
      primed    <= 1'b0;
      pend      <= '0;
      pend_edge <= '0;
      overflow  <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_edge  <= 1'b0;
      rr_last   <= IDX_W'(N_CH - 1);
    end else begin
      in_d      <= in;
      primed    <= 1'b1;
      pend      <= pend_nxt;
      pend_edge <= pend_edge_nxt;
      overflow  <= overflow_nxt;
      if (load) begin
        evt_valid <= gnt_valid;
        if (gnt_valid) begin
          evt_ch   <= gnt_idx;
          evt_edge <= pend_edge[gnt_idx];
          rr_last  <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N_CH = 8).
module tb_edge_event_arbiter;
  import edge_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in;
  logic [15:0] cfg_mode;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_ch;
  logic        evt_edge;
  logic [7:0]  overflow;
  logic [7:0]  ovf_clr;

  int vectors = 0;
  int errors  = 0;

  edge_event_arbiter #(.N_CH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .cfg_mode  (cfg_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_edge  (evt_edge),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release and let the priming edge pass.
  task automatic apply_reset(input logic [7:0] in_v, input logic [15:0] mode_v, input logic rdy);
    rst_n     = 1'b0;
    #2;
    in        = in_v;
    cfg_mode  = mode_v;
    evt_ready = rdy;
    ovf_clr   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in        = 8'hFF;
    cfg_mode  = 16'hFFFF;
    evt_ready = 1'b1;
    ovf_clr   = '0;
    #3;
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    vectors++;
    if (evt_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", evt_ch); end
    vectors++;
    if (evt_edge !== 1'b0) begin errors++; $display("FAIL reset_edge: got %b expected 0", evt_edge); end
    vectors++;
    if (overflow !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h expected 00", overflow); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL prime_no_event cycle %0d: got valid %b expected 0", c, evt_valid);
      end
    end
    vectors++;
    if (overflow !== 8'h00) begin errors++; $display("FAIL prime_ovf: got %h expected 00", overflow); end
  endtask

  task automatic test_single_rise();
    edge_evt_t exp;
    exp.ch     = 5'd3;
    exp.rising = 1'b1;
    apply_reset(8'h00, 16'h0040, 1'b1);
    in[3] = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b expected 0", evt_valid); end
    step();
    vectors++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
    vectors++;
    if (evt_ch !== exp.ch[2:0]) begin errors++; $display("FAIL single_ch: got %0d expected %0d", evt_ch, exp.ch); end
    vectors++;
    if (evt_edge !== exp.rising) begin errors++; $display("FAIL single_edge: got %b expected %b", evt_edge, exp.rising); end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got valid %b expected 0", evt_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ch [3];
    exp_ch[0] = 3'd0;
    exp_ch[1] = 3'd5;
    exp_ch[2] = 3'd7;
    apply_reset(8'h00, 16'hFFFF, 1'b1);
    in = 8'hA1;
    step();
    for (int e = 0; e < 3; e++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b1 || evt_ch !== exp_ch[e] || evt_edge !== 1'b1) begin
        errors++;
        $display("FAIL rr_rise[%0d]: got v=%b ch=%0d e=%b expected v=1 ch=%0d e=1",
                 e, evt_valid, evt_ch, evt_edge, exp_ch[e]);
      end
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got valid %b expected 0", evt_valid); end
    // Pointer now sits at 7, so channel 0 must come before channel 7.
    in = 8'h20;
    step();
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd0 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL rr_wrap_first: got v=%b ch=%0d e=%b expected v=1 ch=0 e=0", evt_valid, evt_ch, evt_edge);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd7 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL rr_wrap_second: got v=%b ch=%0d e=%b expected v=1 ch=7 e=0", evt_valid, evt_ch, evt_edge);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rr_wrap_drain: got valid %b expected 0", evt_valid); end
  endtask

  task automatic test_backpressure_overflow();
    apply_reset(8'h00, 16'h0030, 1'b0);
    in[2] = 1'b1;
    step();
    step();
    in[2] = 1'b0;
    step();
    in[2] = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd2 || evt_edge !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got v=%b ch=%0d e=%b expected v=1 ch=2 e=1", evt_valid, evt_ch, evt_edge);
    end
    vectors++;
    if (overflow !== 8'h04) begin errors++; $display("FAIL bp_ovf: got %h expected 04", overflow); end
    evt_ready = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd2 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: got v=%b ch=%0d e=%b expected v=1 ch=2 e=0", evt_valid, evt_ch, evt_edge);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b expected 0", evt_valid); end
    ovf_clr = 8'h04;
    step();
    ovf_clr = 8'h00;
    vectors++;
    if (overflow !== 8'h00) begin errors++; $display("FAIL bp_ovf_clr: got %h expected 00", overflow); end
  endtask

  task automatic test_fall_and_mode_off();
    apply_reset(8'h00, 16'h0008, 1'b1);
    in[1] = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL fall_no_rise: got valid %b expected 0", evt_valid); end
    in[1] = 1'b0;
    step();
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd1 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL fall_event: got v=%b ch=%0d e=%b expected v=1 ch=1 e=0", evt_valid, evt_ch, evt_edge);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL fall_single: got valid %b expected 0", evt_valid); end
    // Fill slot and pending, then switch the channel off and keep toggling.
    evt_ready = 1'b0;
    in[1] = 1'b1; step();
    in[1] = 1'b0; step();
    step();
    in[1] = 1'b1; step();
    in[1] = 1'b0; step();
    cfg_mode = 16'h0000;
    for (int t = 0; t < 4; t++) begin
      in[1] = ~in[1];
      step();
    end
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd1) begin
      errors++;
      $display("FAIL off_hold: got v=%b ch=%0d expected v=1 ch=1", evt_valid, evt_ch);
    end
    vectors++;
    if (overflow !== 8'h00) begin errors++; $display("FAIL off_ovf: got %h expected 00", overflow); end
    evt_ready = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 3'd1 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL off_drain_pend: got v=%b ch=%0d e=%b expected v=1 ch=1 e=0", evt_valid, evt_ch, evt_edge);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL off_no_more: got valid %b expected 0", evt_valid); end
  endtask

  task automatic test_ovf_priority_and_async_reset();
    apply_reset(8'h00, 16'h0030, 1'b0);
    in[2] = 1'b1; step();
    step();
    in[2] = 1'b0; step();
    in[2] = 1'b1; step();
    vectors++;
    if (overflow !== 8'h04) begin errors++; $display("FAIL ovf_set: got %h expected 04", overflow); end
    in[2]   = 1'b0;
    ovf_clr = 8'h04;
    step();
    ovf_clr = 8'h00;
    vectors++;
    if (overflow !== 8'h04) begin errors++; $display("FAIL ovf_set_wins: got %h expected 04", overflow); end
    ovf_clr = 8'h04;
    step();
    ovf_clr = 8'h00;
    vectors++;
    if (overflow !== 8'h00) begin errors++; $display("FAIL ovf_clear: got %h expected 00", overflow); end
    vectors++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL pre_async_valid: got %b expected 1", evt_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", evt_valid); end
    vectors++;
    if (evt_ch !== 3'd0 || evt_edge !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_slot: got ch=%0d e=%b expected ch=0 e=0", evt_ch, evt_edge);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL async_reset_dropped: got valid %b expected 0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_round_robin();
    test_backpressure_overflow();
    test_fall_and_mode_off();
    test_ovf_priority_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
